scanline_mixer: RTL and testbench

// Post-scandoubler colour/timing stage feeding the VGA/HDMI output path.

---
 rtl/scanline_mixer_if.sv | 39 +++
 rtl/scanline_mixer.sv | 168 ++++++++++++++++
 tb/tb_scanline_mixer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scanline_mixer_if.sv
// Video bus into and out of the scanline mixer: raw CW-bit colour with sync,
// blank and scanline controls in; expanded 8-bit colour with aligned timing out.
interface scanline_mixer_if #(
  parameter int CW = 8
) ();
  // source side
  logic          ce_pix;
  logic [CW-1:0] R;
  logic [CW-1:0] G;
  logic [CW-1:0] B;
  logic          mono;
  logic          HSync;
  logic          VSync;
  logic          HBlank;
  logic          VBlank;
  logic [2:0]    sl_level;
  logic          sl_phase;
  logic          sl_alt;
  // output side
  logic          ce_pix_out;
  logic [7:0]    VGA_R;
  logic [7:0]    VGA_G;
  logic [7:0]    VGA_B;
  logic          VGA_HS;
  logic          VGA_VS;
  logic          VGA_DE;

  modport master (
    output ce_pix, R, G, B, mono, HSync, VSync, HBlank, VBlank,
           sl_level, sl_phase, sl_alt,
    input  ce_pix_out, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
  );

  modport slave (
    input  ce_pix, R, G, B, mono, HSync, VSync, HBlank, VBlank,
           sl_level, sl_phase, sl_alt,
    output ce_pix_out, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
  );
endinterface

// File: rtl/scanline_mixer.sv
// Scanline mixer: CW-bit to 8-bit colour expansion, 8-level scanline dimming
// with line/frame phase control, DE rebuilt from blanking, black outside
// active video. Every output sits exactly two clk_sys cycles behind its input.

// One colour channel: expand to 8 bits (stage 1), then dim / blank (stage 2).
module scanline_lane #(
  parameter int CW = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [CW-1:0] c_raw,
  input  logic          dim1,
  input  logic [2:0]    lvl1,
  input  logic          blank1,
  output logic [7:0]    c_out
);
  logic [7:0]  c_exp;
  logic [7:0]  c1;
  logic [3:0]  keep;
  logic [10:0] prod;

  // Repeat the input MSB-first until 8 bits are filled; CW=8 is a straight copy.
  for (genvar i = 0; i < 8; i++) begin : g_exp
    assign c_exp[7-i] = c_raw[CW-1-(i%CW)];
  end

  // Remaining brightness in eighths; the product is at most 255*8, so 11 bits.
  assign keep = 4'd8 - {1'b0, lvl1};
  assign prod = {3'b000, c1} * {7'd0, keep};

  // Stage 1: hold the expanded colour.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) c1 <= '0;
    else          c1 <= c_exp;
  end

  // Stage 2: floor-scaled colour on dimmed lines, black outside active video.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)    c_out <= '0;
    else if (blank1) c_out <= '0;
    else if (dim1)   c_out <= prod[10:3];
    else             c_out <= c1;
  end
endmodule

module scanline_mixer #(
  parameter int CW          = 8,
  parameter bit BLANK_BLACK = 1'b1
) (
  input logic             clk_sys,
  input logic             reset_n,
  scanline_mixer_if.slave vid
);
  localparam int NUM_LANES = 3;   // lane 2 = R, 1 = G, 0 = B
  localparam int VEC_W     = 8;
  localparam int STAGES    = 2;

  logic [NUM_LANES-1:0][CW-1:0]    c_raw;
  logic [NUM_LANES-1:0][VEC_W-1:0] c_out;

  // Timing sideband; index n is the value after n register stages.
  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] hs_pipe;
  logic [STAGES:1] vs_pipe;

  logic       line_par;
  logic       frame_par;
  logic       hs_fall;
  logic       vs_fall;
  logic       dim;
  logic       hde;
  logic       hde_q;
  logic       de1;
  logic       de2;
  logic       dim1;
  logic [2:0] lvl1;
  logic       blank1;

  // Mono replicates G into all lanes before expansion.
  always_comb begin
    c_raw[2] = vid.mono ? vid.G : vid.R;
    c_raw[1] = vid.G;
    c_raw[0] = vid.mono ? vid.G : vid.B;
  end

  // The stage-1 sync copies double as the edge detectors' history.
  assign hs_fall = hs_pipe[1] & ~vid.HSync;
  assign vs_fall = vs_pipe[1] & ~vid.VSync;

  // Line parity toggles per line; a VS fall restarts it (and wins over a
  // coincident HS fall). With sl_alt the restart value swaps every frame.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      line_par  <= 1'b0;
      frame_par <= 1'b0;
    end else if (vs_fall) begin
      line_par  <= vid.sl_alt ? ~frame_par : 1'b0;
      frame_par <= ~frame_par;
    end else if (hs_fall) begin
      line_par  <= ~line_par;
    end
  end

  // Dim decision uses the parity in force for the pixel sampled this cycle.
  assign dim = (vid.sl_level != 3'd0) && (line_par ^ vid.sl_phase);
  assign hde = ~vid.HBlank;

  // DE latches ~VBlank at the start of each line, so a mid-line VBlank
  // change only shows up on the next line.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hde_q <= 1'b0;
      de1   <= 1'b0;
      de2   <= 1'b0;
    end else begin
      hde_q <= hde;
      if (hde && !hde_q)      de1 <= ~vid.VBlank;
      else if (!hde && hde_q) de1 <= 1'b0;
      de2 <= de1;
    end
  end

  // Stage 1 scanline controls, shared by all lanes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dim1 <= 1'b0;
      lvl1 <= '0;
    end else begin
      dim1 <= dim;
      lvl1 <= vid.sl_level;
    end
  end

  // Two-deep sideband shift registers keep syncs and ce aligned with colour.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vid.ce_pix};
      hs_pipe  <= {hs_pipe[STAGES-1:1],  vid.HSync};
      vs_pipe  <= {vs_pipe[STAGES-1:1],  vid.VSync};
    end
  end

  assign blank1 = BLANK_BLACK && !de1;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    scanline_lane #(.CW(CW)) u_lane (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .c_raw   (c_raw[l]),
      .dim1    (dim1),
      .lvl1    (lvl1),
      .blank1  (blank1),
      .c_out   (c_out[l])
    );
  end

  assign vid.VGA_R      = c_out[2];
  assign vid.VGA_G      = c_out[1];
  assign vid.VGA_B      = c_out[0];
  assign vid.VGA_HS     = hs_pipe[STAGES];
  assign vid.VGA_VS     = vs_pipe[STAGES];
  assign vid.VGA_DE     = de2;
  assign vid.ce_pix_out = vld_pipe[STAGES];
endmodule

// File: tb/tb_scanline_mixer.sv
// Scoreboard bench: three mixers (CW = 8, 5, 1) share one stimulus stream;
// a behavioural model queues expected outputs, a monitor pops and compares.
module tb_scanline_mixer;
  localparam int HT  = 40;   // clocks per line
  localparam int VT  = 12;   // lines per frame
  localparam int NFR = 8;

  typedef struct packed {
    logic            ce, mono, hs, vs, hb, vb, phase, alt;
    logic [2:0]      lvl;
    logic [2:0][7:0] rgb;    // [2]=R [1]=G [0]=B
  } stim_t;

  typedef struct packed {
    logic [2:0][2:0][7:0] rgb;  // [instance][channel]
    logic [2:0]           hs, vs, de, ce;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  scanline_mixer_if #(.CW(8)) if8 ();
  scanline_mixer_if #(.CW(5)) if5 ();
  scanline_mixer_if #(.CW(1)) if1 ();

  scanline_mixer #(.CW(8), .BLANK_BLACK(1'b1)) dut8 (.clk_sys(clk_sys), .reset_n(reset_n), .vid(if8));
  scanline_mixer #(.CW(5), .BLANK_BLACK(1'b1)) dut5 (.clk_sys(clk_sys), .reset_n(reset_n), .vid(if5));
  scanline_mixer #(.CW(1), .BLANK_BLACK(1'b1)) dut1 (.clk_sys(clk_sys), .reset_n(reset_n), .vid(if1));

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pops   = 0;

  // model state
  logic m_lp, m_fp, m_phs, m_pvs, m_phde, m_de;

  function automatic int cw_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 5 : 1;
  endfunction

  function automatic string ch_name(input int c);
    return (c == 2) ? "R" : (c == 1) ? "G" : "B";
  endfunction

  // Concatenate copies of the value until at least 8 bits, keep the top 8.
  function automatic logic [7:0] expand(input logic [7:0] c, input int cw);
    longint v, acc;
    int     w;
    v   = longint'(c) & ((64'd1 << cw) - 1);
    acc = 0;
    w   = 0;
    while (w < 8) begin
      acc = (acc << cw) | v;
      w   = w + cw;
    end
    return 8'(acc >> (w - 8));
  endfunction

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s cw%0d: got %02h expected %02h at %0t", nm, cw_of(k), act, want, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) chk({tag, "_", ch_name(c)}, k, a.rgb[k][c], e.rgb[k][c]);
      chk({tag, "_hs"}, k, {7'd0, a.hs[k]}, {7'd0, e.hs[k]});
      chk({tag, "_vs"}, k, {7'd0, a.vs[k]}, {7'd0, e.vs[k]});
      chk({tag, "_de"}, k, {7'd0, a.de[k]}, {7'd0, e.de[k]});
      chk({tag, "_ce"}, k, {7'd0, a.ce[k]}, {7'd0, e.ce[k]});
    end
  endtask

  function automatic exp_t sample();
    exp_t a;
    a.rgb[0] = {if8.VGA_R, if8.VGA_G, if8.VGA_B};
    a.rgb[1] = {if5.VGA_R, if5.VGA_G, if5.VGA_B};
    a.rgb[2] = {if1.VGA_R, if1.VGA_G, if1.VGA_B};
    a.hs = {if1.VGA_HS, if5.VGA_HS, if8.VGA_HS};
    a.vs = {if1.VGA_VS, if5.VGA_VS, if8.VGA_VS};
    a.de = {if1.VGA_DE, if5.VGA_DE, if8.VGA_DE};
    a.ce = {if1.ce_pix_out, if5.ce_pix_out, if8.ce_pix_out};
    return a;
  endfunction

  task automatic drive(input stim_t s);
    if8.R = s.rgb[2];      if8.G = s.rgb[1];      if8.B = s.rgb[0];
    if5.R = s.rgb[2][4:0]; if5.G = s.rgb[1][4:0]; if5.B = s.rgb[0][4:0];
    if1.R = s.rgb[2][0];   if1.G = s.rgb[1][0];   if1.B = s.rgb[0][0];
    if8.ce_pix = s.ce;  if5.ce_pix = s.ce;  if1.ce_pix = s.ce;
    if8.mono = s.mono;  if5.mono = s.mono;  if1.mono = s.mono;
    if8.HSync = s.hs;   if5.HSync = s.hs;   if1.HSync = s.hs;
    if8.VSync = s.vs;   if5.VSync = s.vs;   if1.VSync = s.vs;
    if8.HBlank = s.hb;  if5.HBlank = s.hb;  if1.HBlank = s.hb;
    if8.VBlank = s.vb;  if5.VBlank = s.vb;  if1.VBlank = s.vb;
    if8.sl_level = s.lvl;   if5.sl_level = s.lvl;   if1.sl_level = s.lvl;
    if8.sl_phase = s.phase; if5.sl_phase = s.phase; if1.sl_phase = s.phase;
    if8.sl_alt = s.alt;     if5.sl_alt = s.alt;     if1.sl_alt = s.alt;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = stim_t'({$urandom, $urandom});
    return s;
  endfunction

  task automatic model_init();
    m_lp = 0; m_fp = 0; m_phs = 0; m_pvs = 0; m_phde = 0; m_de = 0;
  endtask

  // Drive one pixel, queue what the outputs must show two cycles later,
  // then advance the line/frame/DE state as the clock edge will.
  task automatic apply(input stim_t s);
    exp_t       e;
    logic       dim, hde;
    logic [7:0] src, x;
    drive(s);
    dim = (s.lvl != 0) && (m_lp != s.phase);
    hde = !s.hb;
    if (hde && !m_phde)      m_de = !s.vb;
    else if (!hde && m_phde) m_de = 0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        src = s.mono ? s.rgb[1] : s.rgb[c];
        x = expand(src, cw_of(k));
        if (dim)   x = 8'((int'(x) * (8 - int'(s.lvl))) / 8);
        if (!m_de) x = 8'h00;
        e.rgb[k][c] = x;
      end
    end
    e.hs = {3{s.hs}}; e.vs = {3{s.vs}}; e.de = {3{m_de}}; e.ce = {3{s.ce}};
    exp_q.push_back(e);
    if (m_pvs && !s.vs) begin
      m_lp = s.alt ? !m_fp : 1'b0;
      m_fp = !m_fp;
    end else if (m_phs && !s.hs) begin
      m_lp = !m_lp;
    end
    m_phs = s.hs; m_pvs = s.vs; m_phde = hde;
  endtask

  // Leaving reset: pipeline is empty, so the first output is all zero.
  task automatic release_reset();
    reset_n = 1'b1;
    exp_q.delete();
    model_init();
    exp_q.push_back('0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #3;
    release_reset();
  endtask

  // Monitor: in reset everything must read zero; otherwise pop the entry
  // whose pixel has had two clock edges to reach the outputs.
  exp_t mon_a, mon_e;
  always @(posedge clk_sys) begin
    #4;
    mon_a = sample();
    if (!reset_n) begin
      compare("reset", mon_a, '0);
    end else if (exp_q.size() >= 3) begin
      mon_e = exp_q.pop_front();
      n_pops++;
      compare("pix", mon_a, mon_e);
    end
  end

  initial begin
    stim_t      s;
    logic [2:0] ln_lvl;
    logic       ln_phase, fr_alt, fr_same;
    bit         pend;
    model_init();
    s = '0;
    drive(s);
    repeat (6) begin
      @(posedge clk_sys); #2;
      drive(rand_stim());
    end
    pend = 1;
    for (int f = 0; f < NFR; f++) begin
      fr_alt  = (f < 2) ? 1'b0 : (f < 4) ? 1'b1 : 1'($urandom);
      fr_same = (f % 2 == 0) ? 1'b1 : 1'($urandom);
      for (int ln = 0; ln < VT; ln++) begin
        ln_lvl   = (f == 0) ? ((ln < 6) ? 3'd4 : 3'd7) : (f == 1) ? 3'd0 : 3'($urandom);
        ln_phase = (f < 2) ? 1'b0 : 1'($urandom);
        for (int h = 0; h < HT; h++) begin
          s.hb = (h >= 32);
          s.hs = (h >= 34) && (h <= 36);
          s.vb = (ln >= 10) || (ln == 9 && h >= 12);
          s.vs = fr_same ? ((ln == 10 && h >= 37) || (ln == 11 && h < 37))
                         : ((ln == 10 && h >= 20) || (ln == 11 && h < 20));
          s.ce    = 1'($urandom);
          s.alt   = fr_alt;
          s.phase = ln_phase;
          s.lvl   = ln_lvl;
          s.mono  = 1'b0;
          s.rgb   = {8'($urandom), 8'($urandom), 8'($urandom)};
          if (f == 0) begin
            s.rgb = {3{8'hFF}};
          end else if (f == 1) begin
            case (h % 4)
              0: s.rgb = {8'h80, 8'h01, 8'h16};
              1: s.rgb = {8'h16, 8'hFF, 8'h00};
              2: begin s.rgb = {8'hFF, 8'h40, 8'hFF}; s.mono = 1'b1; end
              default: ;
            endcase
          end else if ($urandom_range(15) == 0) begin
            s.lvl   = 3'($urandom);
            s.phase = 1'($urandom);
            s.mono  = 1'($urandom);
          end
          if (f >= 4 && $urandom_range(63) == 0) s.alt = ~s.alt;
          @(posedge clk_sys); #2;
          if (pend) begin release_reset(); pend = 0; end
          if (f == 5 && ln == 4 && h == 15) pulse_reset();
          apply(s);
        end
      end
    end
    repeat (3) @(posedge clk_sys);
    #5;
    n_checks++;
    if (n_pops < NFR * VT * HT - 8) begin
      n_errors++;
      $display("FAIL output_count: got %0d compared pixels expected at least %0d", n_pops, NFR * VT * HT - 8);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
